// File: rtl/cmp_share_arb.sv
// cmp_share_arb: round-robin shared N-bit equality comparator with one-entry registered result buffer
module cmp_share_arb #(
  parameter int N    = 32,
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [NREQ-1:0]   Req_valid,
  output logic [NREQ-1:0]   Req_ready,
  input  logic [NREQ*N-1:0] Vin_a,
  input  logic [NREQ*N-1:0] Vin_b,
  output logic [NREQ-1:0]   Rsp_valid,
  input  logic [NREQ-1:0]   Rsp_ready,
  output logic              Vout,
  output logic [IDW-1:0]    Rsp_id
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;
  logic [IDW-1:0] ptr, gnt_id, lo_id, hi_id;
  logic lo_any, hi_any, can_accept, xfer;
  logic [N-1:0] a_sel, b_sel;
  // Requesters at or after the pointer win; otherwise the lowest valid index wraps around.
  always_comb begin
    lo_any = 1'b0;
    hi_any = 1'b0;
    lo_id = '0;
    hi_id = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (Req_valid[i]) begin
        lo_any = 1'b1;
        lo_id = IDW'(i);
      end
      if (Req_valid[i] && IDW'(i) >= ptr) begin
        hi_any = 1'b1;
        hi_id = IDW'(i);
      end
    end
    gnt_id = hi_any ? hi_id : lo_id;
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        a_sel = Vin_a[i*N +: N];
        b_sel = Vin_b[i*N +: N];
      end
    end
    can_accept = Rst_n && (state == EMPTY || Rsp_ready[Rsp_id]);
    xfer = can_accept && lo_any;
    Req_ready = xfer ? (NREQ'(1) << gnt_id) : '0;
    Rsp_valid = (state == FULL) ? (NREQ'(1) << Rsp_id) : '0;
    state_nxt = xfer ? FULL : (state == FULL && Rsp_ready[Rsp_id]) ? EMPTY : state;
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= EMPTY;
      Vout <= 1'b0;
      Rsp_id <= '0;
      ptr <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        Vout <= (a_sel == b_sel);
        Rsp_id <= gnt_id;
        ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cmp_share_arb.sv
// tb_cmp_share_arb: directed scenarios plus randomized traffic against a behavioural arbitration model
module tb_cmp_share_arb;
  localparam int N = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*N-1:0] vin_a, vin_b;
  logic vout;
  logic [0:0] rsp_id;
  logic [3:0] req_valid4, req_ready4, rsp_valid4, rsp_ready4;
  logic [4*N-1:0] vin_a4, vin_b4;
  logic vout4;
  logic [1:0] rsp_id4;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cmp_share_arb #(.N(N), .NREQ(2), .IDW(1)) dut (
    .Clk(clk), .Rst_n(rst_n), .Req_valid(req_valid), .Req_ready(req_ready),
    .Vin_a(vin_a), .Vin_b(vin_b), .Rsp_valid(rsp_valid), .Rsp_ready(rsp_ready),
    .Vout(vout), .Rsp_id(rsp_id)
  );

  cmp_share_arb #(.N(N), .NREQ(4), .IDW(2)) dut4 (
    .Clk(clk), .Rst_n(rst_n), .Req_valid(req_valid4), .Req_ready(req_ready4),
    .Vin_a(vin_a4), .Vin_b(vin_b4), .Rsp_valid(rsp_valid4), .Rsp_ready(rsp_ready4),
    .Vout(vout4), .Rsp_id(rsp_id4)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    req_valid = 2'b00;
    req_valid4 = 4'h0;
    rsp_ready = 2'b11;
    rsp_ready4 = 4'hF;
    cycle();
    cycle();
    rsp_ready = 2'b00;
    rsp_ready4 = 4'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    vin_a = {32'h1234_5678, 32'hCAFE_F00D};
    vin_b = vin_a;
    cycle();
    cycle();
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    n_cmp++; if (vout !== 1'b0) begin n_err++; $display("FAIL reset_vout got=%b exp=0", vout); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
    n_cmp++; if (rsp_valid4 !== 4'h0) begin n_err++; $display("FAIL reset_rsp_valid4 got=%b exp=0000", rsp_valid4); end
    cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL reset_first_grant got=%b exp=01", req_ready); end
    cycle();
    req_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL reset_first_rsp_valid got=%b exp=01", rsp_valid); end
    n_cmp++; if (vout !== 1'b1) begin n_err++; $display("FAIL reset_first_vout got=%b exp=1", vout); end
    flush();
  endtask

  task automatic test_single();
    vin_a[63:32] = 32'hDEAD_BEEF;
    vin_b[63:32] = 32'hDEAD_BEEF;
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL single_eq_req_ready got=%b exp=10", req_ready); end
    cycle();
    req_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b10) begin n_err++; $display("FAIL single_eq_rsp_valid got=%b exp=10", rsp_valid); end
    n_cmp++; if (vout !== 1'b1) begin n_err++; $display("FAIL single_eq_vout got=%b exp=1", vout); end
    n_cmp++; if (rsp_id !== 1'b1) begin n_err++; $display("FAIL single_eq_rsp_id got=%b exp=1", rsp_id); end
    cycle();
    vin_b[63:32] = 32'hDEAD_BEEE;
    req_valid = 2'b10;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL single_ne_req_ready got=%b exp=10", req_ready); end
    cycle();
    req_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b10) begin n_err++; $display("FAIL single_ne_rsp_valid got=%b exp=10", rsp_valid); end
    n_cmp++; if (vout !== 1'b0) begin n_err++; $display("FAIL single_ne_vout got=%b exp=0", vout); end
    n_cmp++; if (rsp_id !== 1'b1) begin n_err++; $display("FAIL single_ne_rsp_id got=%b exp=1", rsp_id); end
    cycle();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL single_drain got=%b exp=00", rsp_valid); end
    rsp_ready = 2'b00;
    cycle();
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g;
    int c0;
    int c1;
    exp_g = 2'b01;
    c0 = 0;
    c1 = 0;
    vin_a = {32'h0000_0001, 32'h0000_0005};
    vin_b = {32'h0000_0002, 32'h0000_0005};
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_cmp++; if (req_ready !== exp_g) begin n_err++; $display("FAIL fair_grant[%0d] got=%b exp=%b", k, req_ready, exp_g); end
      if (k > 0) begin
        n_cmp++; if (rsp_valid !== ~exp_g) begin n_err++; $display("FAIL fair_rsp_valid[%0d] got=%b exp=%b", k, rsp_valid, ~exp_g); end
        n_cmp++; if (vout !== exp_g[1]) begin n_err++; $display("FAIL fair_vout[%0d] got=%b exp=%b", k, vout, exp_g[1]); end
        n_cmp++; if (rsp_id !== exp_g[0]) begin n_err++; $display("FAIL fair_rsp_id[%0d] got=%b exp=%b", k, rsp_id, exp_g[0]); end
      end
      c0 += int'(req_ready[0]);
      c1 += int'(req_ready[1]);
      exp_g = ~exp_g;
      cycle();
    end
    req_valid = 2'b00;
    n_cmp++; if (c0 != 4) begin n_err++; $display("FAIL fair_count0 got=%0d exp=4", c0); end
    n_cmp++; if (c1 != 4) begin n_err++; $display("FAIL fair_count1 got=%0d exp=4", c1); end
    flush();
  endtask

  task automatic test_backpressure();
    vin_a[31:0] = $urandom;
    vin_b[31:0] = vin_a[31:0];
    vin_a[63:32] = $urandom;
    vin_b[63:32] = ~vin_a[63:32];
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL bp_first_grant got=%b exp=01", req_ready); end
    cycle();
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL bp_hold_req_ready[%0d] got=%b exp=00", k, req_ready); end
      n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL bp_hold_rsp_valid[%0d] got=%b exp=01", k, rsp_valid); end
      n_cmp++; if (vout !== 1'b1) begin n_err++; $display("FAIL bp_hold_vout[%0d] got=%b exp=1", k, vout); end
      n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL bp_hold_rsp_id[%0d] got=%b exp=0", k, rsp_id); end
      cycle();
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL bp_refill_grant got=%b exp=10", req_ready); end
    cycle();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b10) begin n_err++; $display("FAIL bp_refill_rsp_valid got=%b exp=10", rsp_valid); end
    n_cmp++; if (rsp_id !== 1'b1) begin n_err++; $display("FAIL bp_refill_rsp_id got=%b exp=1", rsp_id); end
    n_cmp++; if (vout !== 1'b0) begin n_err++; $display("FAIL bp_refill_vout got=%b exp=0", vout); end
    flush();
  endtask

  task automatic test_wrap();
    vin_a4 = {$urandom, $urandom, $urandom, $urandom};
    vin_b4 = vin_a4;
    rsp_ready4 = 4'hF;
    req_valid4 = 4'b0100;
    @(negedge clk);
    n_cmp++; if (req_ready4 !== 4'b0100) begin n_err++; $display("FAIL wrap_grant2 got=%b exp=0100", req_ready4); end
    cycle();
    req_valid4 = 4'b1001;
    @(negedge clk);
    n_cmp++; if (req_ready4 !== 4'b1000) begin n_err++; $display("FAIL wrap_grant3 got=%b exp=1000", req_ready4); end
    n_cmp++; if (rsp_id4 !== 2'd2) begin n_err++; $display("FAIL wrap_rsp_id2 got=%0d exp=2", rsp_id4); end
    cycle();
    @(negedge clk);
    n_cmp++; if (req_ready4 !== 4'b0001) begin n_err++; $display("FAIL wrap_grant0 got=%b exp=0001", req_ready4); end
    n_cmp++; if (rsp_id4 !== 2'd3) begin n_err++; $display("FAIL wrap_rsp_id3 got=%0d exp=3", rsp_id4); end
    cycle();
    req_valid4 = 4'h0;
    @(negedge clk);
    n_cmp++; if (rsp_valid4 !== 4'b0001) begin n_err++; $display("FAIL wrap_rsp_valid0 got=%b exp=0001", rsp_valid4); end
    n_cmp++; if (vout4 !== 1'b1) begin n_err++; $display("FAIL wrap_vout got=%b exp=1", vout4); end
    flush();
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    cycle();
    req_valid = 2'b11;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL rmid_before_edge got=%b exp=01", rsp_valid); end
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rmid_req_ready0 got=%b exp=00", req_ready); end
    cycle();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL rmid_cleared got=%b exp=00", rsp_valid); end
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rmid_req_ready1 got=%b exp=00", req_ready); end
    cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rmid_regrant got=%b exp=01", req_ready); end
    cycle();
    req_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL rmid_rsp_valid got=%b exp=01", rsp_valid); end
    flush();
  endtask

  task automatic test_random();
    bit full;
    bit mvout;
    bit can;
    int owner;
    int ptr;
    int g;
    int j;
    bit pend [2];
    logic [31:0] oa [2];
    logic [31:0] ob [2];
    logic [1:0] exp_rdy;
    logic [1:0] exp_rv;
    full = 0;
    mvout = 0;
    owner = 0;
    ptr = 0;
    pend[0] = 0;
    pend[1] = 0;
    oa[0] = '0; oa[1] = '0; ob[0] = '0; ob[1] = '0;
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1;
          oa[i] = $urandom;
          ob[i] = ($urandom_range(0, 1) == 1) ? oa[i] : oa[i] ^ (32'h1 << $urandom_range(0, 31));
        end
      end
      req_valid = {pend[1], pend[0]};
      vin_a = {oa[1], oa[0]};
      vin_b = {ob[1], ob[0]};
      rsp_ready = 2'($urandom);
      @(negedge clk);
      can = !full || rsp_ready[owner];
      g = -1;
      for (int k = 0; k < 2; k++) begin
        j = (ptr + k) % 2;
        if (g < 0 && pend[j]) g = j;
      end
      exp_rdy = (can && g >= 0) ? 2'(1 << g) : 2'b00;
      exp_rv = full ? 2'(1 << owner) : 2'b00;
      n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rand_req_ready[%0d] got=%b exp=%b", c, req_ready, exp_rdy); end
      n_cmp++; if (rsp_valid !== exp_rv) begin n_err++; $display("FAIL rand_rsp_valid[%0d] got=%b exp=%b", c, rsp_valid, exp_rv); end
      if (full) begin
        n_cmp++; if (vout !== mvout) begin n_err++; $display("FAIL rand_vout[%0d] got=%b exp=%b", c, vout, mvout); end
        n_cmp++; if (rsp_id !== 1'(owner)) begin n_err++; $display("FAIL rand_rsp_id[%0d] got=%b exp=%0d", c, rsp_id, owner); end
      end
      if (exp_rdy != 2'b00) begin
        full = 1;
        owner = g;
        mvout = (oa[g] == ob[g]);
        ptr = (g + 1) % 2;
        pend[g] = 0;
      end else if (full && rsp_ready[owner]) begin
        full = 0;
      end
      cycle();
    end
    flush();
  endtask

  initial begin
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    vin_a = '0;
    vin_b = '0;
    req_valid4 = 4'h0;
    rsp_ready4 = 4'h0;
    vin_a4 = '0;
    vin_b4 = '0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
